mem_port_arbiter: RTL and testbench

Sequences a single-port synchronous unified memory shared by the instruction-fetch stage and the mem stage (load/store) of the RV32I pipeline. It arbitrates between the two requesters and stalls the loser. Store funct3 is turned into byte enables and replicated write data. Load data is aligned and sign- or zero-extended per load funct3.

---
 rtl/mem_port_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for a single-port unified RV32I memory
// Optional MEM_ARB_MISALIGN_CHK_EN: flag misaligned LH/LHU/SH/LW/SW as errors instead of forcing alignment.
module mem_port_arbiter #(
    parameter int NB_WORD = 32,
    parameter int NB_ADDR = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_req,
    input  logic [NB_ADDR-1:0] if_addr,
    output logic [NB_WORD-1:0] if_rdata,
    output logic               if_valid,
    output logic               if_stall,
    input  logic               dm_rd,
    input  logic               dm_wr,
    input  logic [2:0]         dm_funct3,
    input  logic [NB_ADDR-1:0] dm_addr,
    input  logic [NB_WORD-1:0] dm_wdata,
    output logic [NB_WORD-1:0] dm_rdata,
    output logic               dm_valid,
    output logic               dm_stall,
    output logic               dm_err,
    output logic               mem_en,
    output logic [3:0]         mem_we,
    output logic [NB_ADDR-3:0] mem_addr,
    output logic [NB_WORD-1:0] mem_wdata,
    input  logic [NB_WORD-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_loser_fetch;
    logic [NB_ADDR-1:0] r_addr;
    logic [2:0]         r_funct3;
    logic [NB_WORD-1:0] r_wdata;
    logic               r_is_wr;
    logic               r_is_fetch;

    logic               w_dm_req;
    logic               w_grant_data;
    logic               w_grant_fetch;
    logic               w_illegal;
    logic               w_misalign;
    logic               w_err;
    logic [3:0]         w_we;
    logic [NB_WORD-1:0] w_wdata_rep;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [NB_WORD-1:0] w_load;
    logic               w_if_valid;
    logic               w_dm_valid;
    logic               w_dm_err;
    logic [NB_WORD-1:0] w_if_rdata;
    logic [NB_WORD-1:0] w_dm_rdata;

    assign w_dm_req = dm_rd | dm_wr;

    always_comb begin
        w_grant_data  = 1'b0;
        w_grant_fetch = 1'b0;
        if (r_state == IDLE) begin
            if (w_dm_req && if_req) begin
                w_grant_fetch = r_last_loser_fetch;
                w_grant_data  = ~r_last_loser_fetch;
            end else begin
                w_grant_data  = w_dm_req;
                w_grant_fetch = if_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state            <= IDLE;
            r_last_loser_fetch <= 1'b0;
            r_addr             <= '0;
            r_funct3           <= '0;
            r_wdata            <= '0;
            r_is_wr            <= 1'b0;
            r_is_fetch         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_data || w_grant_fetch) begin
                r_is_fetch <= w_grant_fetch;
                r_addr     <= w_grant_fetch ? if_addr : dm_addr;
                // Fetches reuse the LW path so RESP formatting passes the word untouched.
                r_funct3   <= w_grant_fetch ? 3'b010 : dm_funct3;
                r_wdata    <= dm_wdata;
                r_is_wr    <= w_grant_data & dm_wr;
                if (w_dm_req && if_req) begin
                    r_last_loser_fetch <= w_grant_data;
                end
            end
        end
    end

    always_comb begin
        w_illegal = 1'b0;
        if (r_is_wr) begin
            w_illegal = (r_funct3 > 3'b010);
        end else begin
            case (r_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
                default:                                 w_illegal = 1'b1;
            endcase
        end
    end

`ifdef MEM_ARB_MISALIGN_CHK_EN
    always_comb begin
        w_misalign = 1'b0;
        case (r_funct3[1:0])
            2'b01:   w_misalign = r_addr[0];
            2'b10:   w_misalign = |r_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = ~r_is_fetch & (w_illegal | w_misalign);

    always_comb begin
        w_we        = 4'b1111;
        w_wdata_rep = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_we        = 4'b0001 << r_addr[1:0];
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_we        = 4'b0011 << {r_addr[1], 1'b0};
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            default: begin
                w_we        = 4'b1111;
                w_wdata_rep = r_wdata;
            end
        endcase
    end

    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{(NB_WORD-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(NB_WORD-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(NB_WORD-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(NB_WORD-16){1'b0}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 4'b0000;
        w_if_valid  = 1'b0;
        w_dm_valid  = 1'b0;
        w_dm_err    = 1'b0;
        w_if_rdata  = '0;
        w_dm_rdata  = '0;
        case (r_state)
            IDLE: begin
                if (w_grant_data || w_grant_fetch) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (w_err) begin
                    w_dm_valid  = 1'b1;
                    w_dm_err    = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_is_wr) begin
                    mem_en      = 1'b1;
                    mem_we      = w_we;
                    w_dm_valid  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    mem_en      = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (r_is_fetch) begin
                    w_if_valid = 1'b1;
                    w_if_rdata = mem_rdata;
                end else begin
                    w_dm_valid = 1'b1;
                    w_dm_rdata = w_load;
                end
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Responses are suppressed while reset is asserted; memory strobes are not.
    assign if_valid  = w_if_valid & rst_n;
    assign dm_valid  = w_dm_valid & rst_n;
    assign dm_err    = w_dm_err & rst_n;
    assign if_rdata  = w_if_rdata & {NB_WORD{rst_n}};
    assign dm_rdata  = w_dm_rdata & {NB_WORD{rst_n}};
    assign if_stall  = if_req & ~if_valid;
    assign dm_stall  = w_dm_req & ~dm_valid;
    assign mem_addr  = r_addr[NB_ADDR-1:2];
    assign mem_wdata = w_wdata_rep;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a behavioural memory
module tb_mem_port_arbiter;

    localparam int NB_WORD = 32;
    localparam int NB_ADDR = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               if_req = 1'b0;
    logic [NB_ADDR-1:0] if_addr = '0;
    logic [NB_WORD-1:0] if_rdata;
    logic               if_valid;
    logic               if_stall;
    logic               dm_rd = 1'b0;
    logic               dm_wr = 1'b0;
    logic [2:0]         dm_funct3 = '0;
    logic [NB_ADDR-1:0] dm_addr = '0;
    logic [NB_WORD-1:0] dm_wdata = '0;
    logic [NB_WORD-1:0] dm_rdata;
    logic               dm_valid;
    logic               dm_stall;
    logic               dm_err;
    logic               mem_en;
    logic [3:0]         mem_we;
    logic [NB_ADDR-3:0] mem_addr;
    logic [NB_WORD-1:0] mem_wdata;
    logic [NB_WORD-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NB_WORD(NB_WORD), .NB_ADDR(NB_ADDR)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_funct3(dm_funct3), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall), .dm_err(dm_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem [0:1023];

    always @(posedge clk) begin
        if (mem_en && mem_we == 4'b0000) mem_rdata <= mem[mem_addr[9:0]];
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic [13:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } acc_t;

    rsp_t if_q[$];
    rsp_t dm_q[$];
    acc_t mem_q[$];

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        rsp_t e;
        int   idx;
        if (if_valid) begin
            if (if_q.size() == 0) check("if_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = if_q.pop_front();
                check("if_cycle", cyc, e.cyc);
                check("if_rdata", if_rdata, e.rdata);
            end
        end
        if (dm_valid) begin
            if (dm_q.size() == 0) check("dm_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = dm_q.pop_front();
                check("dm_cycle", cyc, e.cyc);
                check("dm_err", {31'd0, dm_err}, {31'd0, e.err});
                if (e.chk) check("dm_rdata", dm_rdata, e.rdata);
            end
        end
        if (mem_en) begin
            idx = -1;
            foreach (mem_q[i]) if (mem_q[i].cyc == cyc) idx = i;
            if (idx < 0) check("mem_unexpected_access", 32'd1, 32'd0);
            else begin
                check("mem_addr", {18'd0, mem_addr}, {18'd0, mem_q[idx].addr});
                check("mem_we", {28'd0, mem_we}, {28'd0, mem_q[idx].we});
                if (mem_q[idx].we != 4'b0000) check("mem_wdata", mem_wdata, mem_q[idx].wdata);
                mem_q.delete(idx);
            end
        end
    end

    task automatic do_fetch(input logic [15:0] a, input logic [31:0] exp, input int lat);
        int t;
        int n;
        t = cyc;
        if_addr = a;
        if_req  = 1'b1;
        if_q.push_back('{t + lat, exp, 1'b0, 1'b1});
        mem_q.push_back('{t + lat - 1, a[15:2], 4'b0000, 32'h0});
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            check("if_stall", {31'd0, if_stall}, {31'd0, (cyc < t + lat)});
            if (if_valid) break;
        end
        if (n == 30) check("if_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic wr, input logic [2:0] f3, input logic [15:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err,
                           input logic chk_rdata, input int lat, input logic [3:0] exp_we,
                           input logic [31:0] exp_wd);
        int t;
        int n;
        t = cyc;
        dm_rd     = ~wr;
        dm_wr     = wr;
        dm_funct3 = f3;
        dm_addr   = a;
        dm_wdata  = wd;
        dm_q.push_back('{t + lat, exp_rdata, exp_err, chk_rdata});
        if (!exp_err) mem_q.push_back('{wr ? t + lat : t + lat - 1, a[15:2], exp_we, exp_wd});
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            check("dm_stall", {31'd0, dm_stall}, {31'd0, (cyc < t + lat)});
            if (dm_valid) break;
        end
        if (n == 30) check("dm_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        dm_rd = 1'b0;
        dm_wr = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, "_dm_valid"}, {31'd0, dm_valid}, 32'd0);
        check({tag, "_dm_err"}, {31'd0, dm_err}, 32'd0);
        check({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        check({tag, "_mem_we"}, {28'd0, mem_we}, 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4]     = 32'h00500093;
        mem[10'h80] = 32'h80F17F00;
        mem_rdata  = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Simultaneous requests out of reset: data wins first, then fetch.
        fork
            do_fetch(16'h0010, 32'h00500093, 5);
            do_data(1'b0, 3'b010, 16'h0200, 32'h0, 32'h80F17F00, 1'b0, 1'b1, 2, 4'b0000, 32'h0);
        join
        // Second simultaneous pair: fetch lost last time, so it wins now.
        fork
            do_fetch(16'h0010, 32'h00500093, 2);
            do_data(1'b0, 3'b010, 16'h0200, 32'h0, 32'h80F17F00, 1'b0, 1'b1, 5, 4'b0000, 32'h0);
        join

        do_fetch(16'h0013, 32'h00500093, 2);
        do_data(1'b1, 3'b000, 16'h0103, 32'h000000A5, 32'h0, 1'b0, 1'b0, 1, 4'b1000, 32'hA5A5A5A5);
        do_data(1'b0, 3'b000, 16'h0202, 32'h0, 32'hFFFFFFF1, 1'b0, 1'b1, 2, 4'b0000, 32'h0);
        do_data(1'b0, 3'b100, 16'h0202, 32'h0, 32'h000000F1, 1'b0, 1'b1, 2, 4'b0000, 32'h0);
        do_data(1'b0, 3'b001, 16'h0202, 32'h0, 32'hFFFF80F1, 1'b0, 1'b1, 2, 4'b0000, 32'h0);
        do_data(1'b0, 3'b101, 16'h0202, 32'h0, 32'h000080F1, 1'b0, 1'b1, 2, 4'b0000, 32'h0);
        do_data(1'b0, 3'b001, 16'h0200, 32'h0, 32'h00007F00, 1'b0, 1'b1, 2, 4'b0000, 32'h0);
        do_data(1'b0, 3'b100, 16'h0103, 32'h0, 32'h000000A5, 1'b0, 1'b1, 2, 4'b0000, 32'h0);
        do_data(1'b1, 3'b010, 16'h0300, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1, 4'b1111, 32'hCAFEF00D);
        do_data(1'b1, 3'b001, 16'h0302, 32'h1234BEEF, 32'h0, 1'b0, 1'b0, 1, 4'b1100, 32'hBEEFBEEF);
        do_data(1'b0, 3'b010, 16'h0300, 32'h0, 32'hBEEFF00D, 1'b0, 1'b1, 2, 4'b0000, 32'h0);
`ifdef MEM_ARB_MISALIGN_CHK_EN
        do_data(1'b0, 3'b001, 16'h0301, 32'h0, 32'h0, 1'b1, 1'b1, 1, 4'b0000, 32'h0);
        do_data(1'b0, 3'b010, 16'h0202, 32'h0, 32'h0, 1'b1, 1'b1, 1, 4'b0000, 32'h0);
`else
        do_data(1'b0, 3'b001, 16'h0301, 32'h0, 32'hFFFFF00D, 1'b0, 1'b1, 2, 4'b0000, 32'h0);
        do_data(1'b0, 3'b010, 16'h0202, 32'h0, 32'h80F17F00, 1'b0, 1'b1, 2, 4'b0000, 32'h0);
`endif
        do_data(1'b1, 3'b101, 16'h0300, 32'h11111111, 32'h0, 1'b1, 1'b1, 1, 4'b0000, 32'h0);
        do_data(1'b0, 3'b011, 16'h0300, 32'h0, 32'h0, 1'b1, 1'b1, 1, 4'b0000, 32'h0);
        do_data(1'b0, 3'b110, 16'h0300, 32'h0, 32'h0, 1'b1, 1'b1, 1, 4'b0000, 32'h0);
        do_data(1'b0, 3'b010, 16'h0300, 32'h0, 32'hBEEFF00D, 1'b0, 1'b1, 2, 4'b0000, 32'h0);

        // Reset asserted during the RESP cycle of a load.
        t = cyc;
        dm_rd     = 1'b1;
        dm_funct3 = 3'b010;
        dm_addr   = 16'h0200;
        mem_q.push_back('{t + 1, 14'h0080, 4'b0000, 32'h0});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_resp_dm_valid", {31'd0, dm_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dm_rd = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");
        @(posedge clk);
        #1;

        do_fetch(16'h0010, 32'h00500093, 2);
        do_data(1'b0, 3'b100, 16'h0202, 32'h0, 32'h000000F1, 1'b0, 1'b1, 2, 4'b0000, 32'h0);

        repeat (3) @(posedge clk);
        check("if_q_empty", if_q.size(), 32'd0);
        check("dm_q_empty", dm_q.size(), 32'd0);
        check("mem_q_empty", mem_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
